alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Upstream feeder and result-capture stage for the 8-bit combinational ALU.
//  - Accepts ALU commands {a, b, op} over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
//  - Drives the FIFO head onto the ALU operand/opcode inputs.
//  - Registers the ALU result, with the opcode and an illegal-op flag, into an output slot with its own valid/ready handshake.
//  - Keeps a completed-transfer counter.
// PARAMETERS
//  DEPTH   4   command FIFO entries; power of 2, >= 2
//  CNT_W   16  width of done_cnt
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      synchronous, active-low reset
//  in_valid    in   1      command present on in_a/in_b/in_op
//  in_ready    out  1      stage can accept a command this cycle
//  in_a        in   8      operand a
//  in_b        in   8      operand b
//  in_op       in   3      opcode; 0 add, 1 sub, 2 and, 3 or, 4 xor, 5-7 illegal
//  alu_a       out  8      to ALU a (FIFO head a; 0 when FIFO empty)
//  alu_b       out  8      to ALU b (FIFO head b; 0 when FIFO empty)
//  alu_op      out  3      to ALU op (FIFO head op; 0 when FIFO empty)
//  alu_result  in   8      from ALU result (combinational from alu_a/alu_b/alu_op)
//  out_valid   out  1      out_result/out_op/out_err hold a completed command
//  out_ready   in   1      downstream accepts the output this cycle
//  out_result  out  8      captured ALU result
//  out_op      out  3      opcode of the captured command
//  out_err     out  1      1 when out_op is 5, 6 or 7
//  done_cnt    out  CNT_W  number of output handshakes since reset
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge):
//   - FIFO empties (pointers and count = 0).
//   - out_valid=0, out_result=0, out_op=0, out_err=0, done_cnt=0.
//   - in_ready=0 while rst_n is low.
//   - Reset mid-operation discards all buffered and captured commands; no partial output appears.
//  Input side:
//   - push = in_valid & in_ready.
//   - in_ready = rst_n & (count < DEPTH); it is registered-state-derived with no combinational path from out_ready.
//   - in_a/in_b/in_op may change freely while in_ready=0.
//  Issue:
//   - pop = (count != 0) & (!out_valid | out_ready).
//   - On pop, out_result <= alu_result, out_op <= head op, out_err <= (head op >= 5), out_valid <= 1.
//   - Otherwise, if out_valid & out_ready, out_valid <= 0.
//   - Output fields hold stable while out_valid=1 and out_ready=0.
//  Output:
//   - Handshake = out_valid & out_ready.
//   - done_cnt increments by 1 per handshake and wraps modulo 2^CNT_W.
//  FIFO:
//   - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
//   - count: push only -> +1; pop only -> -1; push and pop in the same cycle -> unchanged.
//   - Full: count==DEPTH, in_ready=0, no push. Empty: count==0, no pop, alu_a/alu_b/alu_op = 0.
//  Latency:
//   - A command accepted at edge N into an empty stage, with output free, is on the ALU inputs in cycle N+1.
//   - It is captured at edge N+1; out_valid is high in cycle N+2.
//  Throughput: with out_ready held 1, one command per cycle sustained.
//  Arithmetic is performed only by the ALU.
//   - 8-bit, carry/borrow discarded; sub wraps modulo 256.
//   - Illegal ops return 0 and are passed through with out_err=1, never dropped.
//  Ordering: strictly FIFO; outputs appear in acceptance order.
// TESTING
//  1. a=10, b=3, op=0, out_ready=1 -> out_result=13 (0x0D), out_err=0, out_valid in cycle N+2, done_cnt=1.
//  2. Back-to-back ops 1, 2, 3, 4 with a=10, b=3 -> outputs 7, 2, 11, 9 in order on consecutive cycles.
//  3. Wrap: 200+100 -> 0x2C; 3-10 (op=1) -> 0xF9.
//  4. out_ready=0, push 5 commands -> 4 accepted, in_ready=0 after 4th.
//     Release out_ready -> all 4 drain in order, in_ready returns 1.
//  5. op=5, a=7, b=7 -> out_result=0, out_op=5, out_err=1, done_cnt increments.
//  6. rst_n low for one edge with 3 commands buffered and out_valid=1 -> out_valid=0, done_cnt=0, in_ready=1 next cycle, no stale output.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Command FIFO feeding an external combinational 8-bit ALU, with a registered
// result slot on its own valid/ready handshake and a completed-transfer counter.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [2:0]       in_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [7:0]       alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_result,
    output logic [2:0]       out_op,
    output logic             out_err,
    output logic [CNT_W-1:0] done_cnt
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and in_ready never on out_ready.
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [7:0]       a_mem_q  [DEPTH];
    logic [7:0]       b_mem_q  [DEPTH];
    logic [2:0]       op_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_result_q, out_result_d;
    logic [2:0]       out_op_q, out_op_d;
    logic             out_err_q, out_err_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic             empty, push, pop, out_hs;

    assign empty    = (count_q == '0);
    assign in_ready = rst_n & (count_q < FULL_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = !empty & (!out_valid_q | out_ready);
    assign out_hs   = out_valid_q & out_ready;

    assign alu_a  = empty ? 8'h00 : a_mem_q[rd_ptr_q];
    assign alu_b  = empty ? 8'h00 : b_mem_q[rd_ptr_q];
    assign alu_op = empty ? 3'd0  : op_mem_q[rd_ptr_q];

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_op     = out_op_q;
    assign out_err    = out_err_q;
    assign done_cnt   = done_cnt_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_err_d    = out_err_q;
        done_cnt_d   = done_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A pop refills the slot in the same edge the old result leaves it.
        if (pop) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_op_d     = alu_op;
            out_err_d    = (alu_op >= 3'd5);
        end else if (out_hs) begin
            out_valid_d  = 1'b0;
        end

        if (out_hs) done_cnt_d = done_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= 8'h00;
            out_op_q     <= 3'd0;
            out_err_q    <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_err_q    <= out_err_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem_q[wr_ptr_q]  <= in_a;
            b_mem_q[wr_ptr_q]  <= in_b;
            op_mem_q[wr_ptr_q] <= in_op;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: supplies the combinational ALU, tracks a queue-based
// model of the stage every cycle, and pins it with directed literal results.
module tb_alu_issue_stage;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [2:0]       in_op;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [2:0]       alu_op;
    logic [7:0]       alu_result;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic [2:0]       out_op;
    logic             out_err;
    logic [CNT_W-1:0] done_cnt;

    alu_issue_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_err(out_err),
        .done_cnt(done_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef struct {
        logic [7:0] res;
        logic [2:0] op;
        logic       err;
        int         cyc;
    } out_t;

    cmd_t       mq[$];
    logic       m_valid;
    logic [7:0] m_res;
    logic [2:0] m_op;
    logic       m_err;
    logic [CNT_W-1:0] m_cnt;
    logic       m_init = 1'b0;
    int         cyc = 0;
    out_t       dut_log[$];

    task automatic model_step();
        bit   do_push, do_pop, do_hs;
        cmd_t c;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_res   = 8'h00;
            m_op    = 3'd0;
            m_err   = 1'b0;
            m_cnt   = '0;
            m_init  = 1'b1;
            return;
        end
        if (!m_init) return;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() != 0) && (!m_valid || out_ready);
        do_hs   = m_valid && out_ready;
        if (do_hs) m_cnt = m_cnt + 1'b1;
        if (do_pop) begin
            c       = mq.pop_front();
            m_valid = 1'b1;
            m_res   = alu_f(c.a, c.b, c.op);
            m_op    = c.op;
            m_err   = (c.op >= 3'd5);
        end else if (do_hs) begin
            m_valid = 1'b0;
        end
        if (do_push) begin
            c.a  = in_a;
            c.b  = in_b;
            c.op = in_op;
            mq.push_back(c);
        end
    endtask

    task automatic compare();
        logic       exp_rdy;
        logic [7:0] ea, eb;
        logic [2:0] eo;
        if (!m_init) return;
        exp_rdy = rst_n && (mq.size() < DEPTH);
        ea = (mq.size() != 0) ? mq[0].a  : 8'h00;
        eb = (mq.size() != 0) ? mq[0].b  : 8'h00;
        eo = (mq.size() != 0) ? mq[0].op : 3'd0;
        check("in_ready",  32'(in_ready),  32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("alu_a",     32'(alu_a),     32'(ea));
        check("alu_b",     32'(alu_b),     32'(eb));
        check("alu_op",    32'(alu_op),    32'(eo));
        check("done_cnt",  32'(done_cnt),  32'(m_cnt));
        if (m_valid) begin
            check("out_result", 32'(out_result), 32'(m_res));
            check("out_op",     32'(out_op),     32'(m_op));
            check("out_err",    32'(out_err),    32'(m_err));
        end
        if (rst_n && out_valid && out_ready)
            dut_log.push_back('{res: out_result, op: out_op, err: out_err, cyc: cyc});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (called at posedge + 2) ----------------
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int max_wait, output bit acc);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(posedge clk);
            if (in_ready) acc = 1'b1;
            #2;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bit acc;
        send(a, b, op, 20, acc);
        check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_log(input int n, input int budget);
        int i;
        for (i = 0; i < budget && dut_log.size() < n; i++) @(negedge clk);
        check("wait_log_timeout", 32'(dut_log.size() >= n), 32'd1);
    endtask

    task automatic check_log(input string name, input int idx, input logic [7:0] res,
                             input logic [2:0] op, input logic err);
        if (idx >= dut_log.size()) begin
            check({name, "_missing"}, 32'(dut_log.size()), 32'(idx + 1));
        end else begin
            check({name, "_res"}, 32'(dut_log[idx].res), 32'(res));
            check({name, "_op"},  32'(dut_log[idx].op),  32'(op));
            check({name, "_err"}, 32'(dut_log[idx].err), 32'(err));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int n_acc;
        bit acc;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_op",     32'(out_op),     32'd0);
        check("rst_out_err",    32'(out_err),    32'd0);
        check("rst_done_cnt",   32'(done_cnt),   32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_alu_a",      32'(alu_a),      32'd0);
        @(posedge clk); #2;

        // 10 + 3: on ALU in cycle N+1, out_valid in cycle N+2
        send_ok(8'd10, 8'd3, 3'd0);
        @(negedge clk);
        check("t1_valid_n1", 32'(out_valid), 32'd0);
        check("t1_alu_a_n1", 32'(alu_a),     32'd10);
        @(negedge clk);
        check("t1_valid_n2", 32'(out_valid),  32'd1);
        check("t1_result",   32'(out_result), 32'h0D);
        check("t1_err",      32'(out_err),    32'd0);
        @(negedge clk);
        check("t1_done_cnt", 32'(done_cnt),   32'd1);
        @(posedge clk); #2;

        // back-to-back sub/and/or/xor
        base = dut_log.size();
        for (int op = 1; op <= 4; op++) send_ok(8'd10, 8'd3, 3'(op));
        wait_log(base + 4, 20);
        check_log("t2_sub", base + 0, 8'd7,  3'd1, 1'b0);
        check_log("t2_and", base + 1, 8'd2,  3'd2, 1'b0);
        check_log("t2_or",  base + 2, 8'd11, 3'd3, 1'b0);
        check_log("t2_xor", base + 3, 8'd9,  3'd4, 1'b0);
        if (dut_log.size() >= base + 4)
            for (int i = 1; i < 4; i++)
                check("t2_consecutive", 32'(dut_log[base+i].cyc - dut_log[base].cyc), 32'(i));
        @(posedge clk); #2;

        // wrap-around
        base = dut_log.size();
        send_ok(8'd200, 8'd100, 3'd0);
        send_ok(8'd3,   8'd10,  3'd1);
        wait_log(base + 2, 20);
        check_log("t3_addwrap", base + 0, 8'h2C, 3'd0, 1'b0);
        check_log("t3_subwrap", base + 1, 8'hF9, 3'd1, 1'b0);
        @(posedge clk); #2;

        // backpressure: occupy the slot, then 4 of 5 commands fit in the FIFO
        out_ready = 1'b0;
        base = dut_log.size();
        send_ok(8'd1, 8'd1, 3'd0);
        repeat (2) @(negedge clk);
        check("t4_slot_full", 32'(out_valid), 32'd1);
        @(posedge clk); #2;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'(20 + i), 8'd1, 3'd0, 3, acc);
            if (acc) n_acc++;
        end
        check("t4_accepted", 32'(n_acc), 32'd4);
        @(negedge clk);
        check("t4_in_ready_full", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_log(base + 5, 30);
        check_log("t4_d0", base + 0, 8'd2,  3'd0, 1'b0);
        check_log("t4_d1", base + 1, 8'd21, 3'd0, 1'b0);
        check_log("t4_d2", base + 2, 8'd22, 3'd0, 1'b0);
        check_log("t4_d3", base + 3, 8'd23, 3'd0, 1'b0);
        check_log("t4_d4", base + 4, 8'd24, 3'd0, 1'b0);
        @(negedge clk);
        check("t4_in_ready_back", 32'(in_ready), 32'd1);
        @(posedge clk); #2;

        // illegal op passes through with err
        base = dut_log.size();
        send_ok(8'd7, 8'd7, 3'd5);
        wait_log(base + 1, 20);
        check_log("t5_illegal", base, 8'd0, 3'd5, 1'b1);
        @(negedge clk);
        check("t5_done_cnt", 32'(done_cnt), 32'd13);
        @(posedge clk); #2;

        // reset with 3 buffered and one captured
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_ok(8'(40 + i), 8'd2, 3'd0);
        @(negedge clk);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_valid",    32'(out_valid), 32'd0);
        check("t6_done_cnt", 32'(done_cnt),  32'd0);
        check("t6_in_ready", 32'(in_ready),  32'd1);
        base = dut_log.size();
        repeat (6) @(negedge clk);
        check("t6_no_stale", 32'(dut_log.size()), 32'(base));
        @(posedge clk); #2;
        send_ok(8'd5, 8'd6, 3'd0);
        wait_log(base + 1, 20);
        check_log("t6_fresh", base, 8'd11, 3'd0, 1'b0);
        @(negedge clk);
        check("t6_done_cnt_after", 32'(done_cnt), 32'd1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
